// File: rtl/cp0_reg.sv
// Coprocessor-0 register block: Count/Compare timer, Status/Cause/EPC/BadVAddr,
// exception and ERET capture, and a registered interrupt-pending flag.
module cp0_reg #(
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [4:0]  raddr_i,
   input  logic [31:0] data_i,
   input  logic [5:0]  int_i,
   input  logic        exc_valid_i,
   input  logic [4:0]  exc_code_i,
   input  logic [31:0] exc_pc_i,
   input  logic        exc_bd_i,
   input  logic [31:0] exc_badvaddr_i,
   input  logic        eret_i,
   output logic [31:0] data_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] badvaddr_o,
   output logic        timer_int_o,
   output logic        int_pending_o
);

   localparam logic [4:0]  REG_BADVADDR = 5'd8;
   localparam logic [4:0]  REG_COUNT    = 5'd9;
   localparam logic [4:0]  REG_COMPARE  = 5'd11;
   localparam logic [4:0]  REG_STATUS   = 5'd12;
   localparam logic [4:0]  REG_CAUSE    = 5'd13;
   localparam logic [4:0]  REG_EPC      = 5'd14;
   localparam logic [31:0] STATUS_MASK  = 32'h0000_FF03;

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [31:0] status_q, status_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] badvaddr_q, badvaddr_d;
   logic        tick_q, tick_d;
   logic        timer_q, timer_d;
   logic        pend_q, pend_d;
   logic        swWrite;

   // Exceptions and ERET swallow any software write committing in the same cycle.
   assign swWrite = we_i & ~exc_valid_i & ~eret_i;

   always_comb begin
      tick_d     = ~tick_q;
      count_d    = count_q + {31'd0, tick_q};
      compare_d  = compare_q;
      status_d   = status_q;
      cause_d    = cause_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      timer_d    = timer_q | ((count_q == compare_q) && (compare_q != 32'd0));

      if (swWrite && (waddr_i == REG_COUNT)) begin
         count_d = data_i;
      end
      if (swWrite && (waddr_i == REG_COMPARE)) begin
         compare_d = data_i;
         timer_d   = 1'b0;
      end

      if (exc_valid_i) begin
         cause_d[6:2] = exc_code_i;
         // A nested exception keeps the original return point.
         if (!status_q[1]) begin
            epc_d       = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
            cause_d[31] = exc_bd_i;
         end
         status_d[1] = 1'b1;
         if ((exc_code_i == 5'd4) || (exc_code_i == 5'd5)) begin
            badvaddr_d = exc_badvaddr_i;
         end
      end else if (eret_i) begin
         status_d[1] = 1'b0;
      end else if (we_i) begin
         case (waddr_i)
            REG_STATUS: status_d     = (status_q & ~STATUS_MASK) | (data_i & STATUS_MASK);
            REG_CAUSE:  cause_d[9:8] = data_i[9:8];
            REG_EPC:    epc_d        = data_i;
            default:    ;
         endcase
      end

      cause_d[15]    = int_i[5] | timer_d;
      cause_d[14:10] = int_i[4:0];

      pend_d = status_d[0] & ~status_d[1] & (|(cause_d[15:8] & status_d[15:8]));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= 32'd0;
         compare_q  <= 32'd0;
         status_q   <= STATUS_RST;
         cause_q    <= 32'd0;
         epc_q      <= 32'd0;
         badvaddr_q <= 32'd0;
         tick_q     <= 1'b0;
         timer_q    <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         count_q    <= count_d;
         compare_q  <= compare_d;
         status_q   <= status_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
         tick_q     <= tick_d;
         timer_q    <= timer_d;
         pend_q     <= pend_d;
      end
   end

   always_comb begin
      data_o = 32'd0;
      case (raddr_i)
         REG_BADVADDR: data_o = badvaddr_q;
         REG_COUNT:    data_o = count_q;
         REG_COMPARE:  data_o = compare_q;
         REG_STATUS:   data_o = status_q;
         REG_CAUSE:    data_o = cause_q;
         REG_EPC:      data_o = epc_q;
         default:      data_o = 32'd0;
      endcase
   end

   assign count_o       = count_q;
   assign compare_o     = compare_q;
   assign status_o      = status_q;
   assign cause_o       = cause_q;
   assign epc_o         = epc_q;
   assign badvaddr_o    = badvaddr_q;
   assign timer_int_o   = timer_q;
   assign int_pending_o = pend_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed testbench for cp0_reg with hand-computed expectations.
module tb_cp0_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [4:0]  raddr_i;
   logic [31:0] data_i;
   logic [5:0]  int_i;
   logic        exc_valid_i;
   logic [4:0]  exc_code_i;
   logic [31:0] exc_pc_i;
   logic        exc_bd_i;
   logic [31:0] exc_badvaddr_i;
   logic        eret_i;
   logic [31:0] data_o;
   logic [31:0] count_o;
   logic [31:0] compare_o;
   logic [31:0] status_o;
   logic [31:0] cause_o;
   logic [31:0] epc_o;
   logic [31:0] badvaddr_o;
   logic        timer_int_o;
   logic        int_pending_o;

   int totalChecks = 0;
   int badChecks   = 0;

   cp0_reg #(.STATUS_RST(32'h0040_0000)) dut (
      .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
      .data_i(data_i), .int_i(int_i), .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i),
      .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i), .exc_badvaddr_i(exc_badvaddr_i),
      .eret_i(eret_i), .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
      .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
      .timer_int_o(timer_int_o), .int_pending_o(int_pending_o)
   );

   always #5 clk = ~clk;

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] value);
      we_i    = 1'b1;
      waddr_i = addr;
      data_i  = value;
      stepClock();
      we_i    = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      int waitCycles;
      rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; raddr_i = 5'd0; data_i = 32'd0;
      int_i = 6'd0; exc_valid_i = 1'b0; exc_code_i = 5'd0; exc_pc_i = 32'd0;
      exc_bd_i = 1'b0; exc_badvaddr_i = 32'd0; eret_i = 1'b0;

      stepClock();
      stepClock();
      rst = 1'b0;
      checkOutput("rst_status", status_o, 32'h0040_0000);
      checkOutput("rst_cause", cause_o, 32'h0);
      checkOutput("rst_count0", count_o, 32'd0);
      checkOutput("rst_pending", {31'd0, int_pending_o}, 32'd0);
      stepClock(); checkOutput("count_e1", count_o, 32'd0);
      stepClock(); checkOutput("count_e2", count_o, 32'd1);
      stepClock(); checkOutput("count_e3", count_o, 32'd1);
      stepClock(); checkOutput("count_e4", count_o, 32'd2);

      // Count write lands while tick is low, so the wrap takes three further edges.
      applyStimulus(5'd9, 32'hFFFF_FFFE);
      checkOutput("count_load", count_o, 32'hFFFF_FFFE);
      stepClock(); checkOutput("count_ffff", count_o, 32'hFFFF_FFFF);
      stepClock();
      stepClock(); checkOutput("count_wrap", count_o, 32'd0);

      applyStimulus(5'd11, 32'd10);
      applyStimulus(5'd12, 32'h0000_8001);
      checkOutput("status_im7", status_o, 32'h0040_8001);
      waitCycles = 0;
      while (count_o != 32'd10 && waitCycles < 100) begin
         checkOutput("timer_early", {31'd0, timer_int_o}, 32'd0);
         stepClock();
         waitCycles++;
      end
      checkOutput("count_reach10", count_o, 32'd10);
      checkOutput("timer_pre", {31'd0, timer_int_o}, 32'd0);
      stepClock();
      checkOutput("timer_set", {31'd0, timer_int_o}, 32'd1);
      checkOutput("timer_cause15", {31'd0, cause_o[15]}, 32'd1);
      checkOutput("timer_pending", {31'd0, int_pending_o}, 32'd1);
      stepClock();
      checkOutput("timer_sticky", {31'd0, timer_int_o}, 32'd1);
      applyStimulus(5'd11, 32'd20);
      checkOutput("timer_clear", {31'd0, timer_int_o}, 32'd0);
      checkOutput("timer_clr_cause", {31'd0, cause_o[15]}, 32'd0);
      checkOutput("timer_clr_pend", {31'd0, int_pending_o}, 32'd0);
      applyStimulus(5'd11, 32'd0);

      exc_valid_i = 1'b1; exc_code_i = 5'd5; exc_pc_i = 32'hBFC0_0104;
      exc_bd_i = 1'b1; exc_badvaddr_i = 32'h0000_0003;
      stepClock();
      exc_valid_i = 1'b0;
      checkOutput("exc_epc", epc_o, 32'hBFC0_0100);
      checkOutput("exc_cause", cause_o, 32'h8000_0014);
      checkOutput("exc_status", status_o, 32'h0040_8003);
      checkOutput("exc_badvaddr", badvaddr_o, 32'h0000_0003);

      exc_valid_i = 1'b1; exc_code_i = 5'd12; exc_pc_i = 32'h0000_1234;
      exc_bd_i = 1'b0; exc_badvaddr_i = 32'h0000_DEAD;
      stepClock();
      exc_valid_i = 1'b0;
      checkOutput("exc2_epc", epc_o, 32'hBFC0_0100);
      checkOutput("exc2_cause", cause_o, 32'h8000_0030);
      checkOutput("exc2_badvaddr", badvaddr_o, 32'h0000_0003);

      exc_valid_i = 1'b1; exc_code_i = 5'd10; eret_i = 1'b1;
      we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h5555_5555;
      stepClock();
      exc_valid_i = 1'b0; eret_i = 1'b0; we_i = 1'b0;
      checkOutput("prio_epc", epc_o, 32'hBFC0_0100);
      checkOutput("prio_cause", cause_o, 32'h8000_0028);
      checkOutput("prio_exl", {31'd0, status_o[1]}, 32'd1);

      eret_i = 1'b1;
      applyStimulus(5'd12, 32'h0000_0000);
      eret_i = 1'b0;
      checkOutput("eret_status", status_o, 32'h0040_8001);

      // Reset with every commit input asserted must win.
      rst = 1'b1; exc_valid_i = 1'b1; exc_code_i = 5'd4; eret_i = 1'b1;
      applyStimulus(5'd14, 32'hAAAA_AAAA);
      rst = 1'b0; exc_valid_i = 1'b0; eret_i = 1'b0;
      checkOutput("mid_rst_status", status_o, 32'h0040_0000);
      checkOutput("mid_rst_epc", epc_o, 32'h0);
      checkOutput("mid_rst_cause", cause_o, 32'h0);
      checkOutput("mid_rst_bva", badvaddr_o, 32'h0);
      checkOutput("mid_rst_count", count_o, 32'h0);

      applyStimulus(5'd12, 32'hFFFF_FFFF);
      checkOutput("mask_status", status_o, 32'h0040_FF03);
      applyStimulus(5'd13, 32'hFFFF_FFFF);
      checkOutput("mask_cause", cause_o, 32'h0000_0300);
      checkOutput("mask_pending", {31'd0, int_pending_o}, 32'd0);
      applyStimulus(5'd8, 32'h1234_5678);
      checkOutput("ro_badvaddr", badvaddr_o, 32'h0);
      raddr_i = 5'd3; #1;
      checkOutput("read_unmapped", data_o, 32'h0);
      raddr_i = 5'd12; #1;
      checkOutput("read_status", data_o, 32'h0040_FF03);
      raddr_i = 5'd14; we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h0BAD_F00D; #1;
      checkOutput("read_nobypass", data_o, 32'h0);
      stepClock();
      we_i = 1'b0;
      checkOutput("read_epc_after", data_o, 32'h0BAD_F00D);

      applyStimulus(5'd12, 32'h0000_0401);
      checkOutput("hw_status", status_o, 32'h0040_0401);
      int_i = 6'b000001;
      stepClock();
      checkOutput("hw_cause10", {31'd0, cause_o[10]}, 32'd1);
      checkOutput("hw_pending", {31'd0, int_pending_o}, 32'd1);
      int_i = 6'b000000;
      stepClock();
      checkOutput("hw_cause10_clr", {31'd0, cause_o[10]}, 32'd0);
      checkOutput("hw_pending_clr", {31'd0, int_pending_o}, 32'd0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
